// File: rtl/dcache_write_buffer_pkg.sv
// Shared definitions for the data-cache write buffer: widths, FSM encoding, entry layout.
package dcache_write_buffer_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MWRITE = 2'd1,
    ST_MREAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/dcache_write_buffer_fifo.sv
// wbuf_fifo: circular buffer of pending block writes with a fully associative address lookup.
// The forwarded-data output exists only when WBUF_FORWARD_EN is defined.
module wbuf_fifo
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              wr_en,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output entry_t            head,
  output logic              match,
`ifdef WBUF_FORWARD_EN
  output logic [DATA_W-1:0] match_data,
`endif
  output logic              match_head
);

  localparam int PW = $clog2(DEPTH);

  entry_t           mem_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [PW:0]      count_reg;
  logic [PW-1:0]    match_idx;
  logic [DEPTH-1:0] hit;
  logic             push;

  // A slot is live when its distance from head is below count; pointers wrap naturally.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] offset;
      assign offset  = PW'(gi) - head_reg;
      assign hit[gi] = ({1'b0, offset} < count_reg) && (mem_reg[gi].addr == lookup_addr);
    end
  endgenerate

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) match_idx = PW'(i);
    end
  end

`ifdef WBUF_FORWARD_EN
  always_comb begin
    match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) match_data = mem_reg[i].data;
    end
  end
`endif

  assign match      = |hit;
  assign match_head = hit[head_reg];
  assign head       = mem_reg[head_reg];
  assign full       = (count_reg == (PW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push       = wr_en && !match;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Addresses stay unique: a hit rewrites data in place instead of allocating.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (match) mem_reg[match_idx].data <= wr_data;
      else       mem_reg[tail_reg]       <= '{addr: lookup_addr, data: wr_data};
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between a data cache and data memory: queues evictions, arbitrates memory reads vs drains.
// Defining WBUF_FORWARD_EN lets reads hitting a buffered block return its data without a memory access.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              C_READ,
  input  logic              C_WRITE,
  input  logic [ADDR_W-1:0] C_ADDRESS,
  input  logic [DATA_W-1:0] C_WRITEDATA,
  output logic [DATA_W-1:0] C_READDATA,
  output logic              C_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_t            state_reg, state_next;
  logic              read_done_reg, read_done_next;
  logic [DATA_W-1:0] read_data_reg;
  logic [ADDR_W-1:0] read_addr_reg;

  logic   fifo_full, fifo_empty, match, match_head;
  entry_t head;
  logic   head_locked, wr_accept, read_ready, read_miss, mem_done, pop;
`ifdef WBUF_FORWARD_EN
  logic [DATA_W-1:0] match_data;
`endif

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .srst_n      (RESET),
    .wr_en       (wr_accept),
    .pop         (pop),
    .lookup_addr (C_ADDRESS),
    .wr_data     (C_WRITEDATA),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (head),
    .match       (match),
`ifdef WBUF_FORWARD_EN
    .match_data  (match_data),
`endif
    .match_head  (match_head)
  );

  assign mem_done = (state_reg != ST_IDLE) && !MEM_BUSYWAIT;
  assign pop      = (state_reg == ST_MWRITE) && !MEM_BUSYWAIT;

  // The head being drained must not change under the memory, so a hit on it waits for retire.
  always_comb begin
    head_locked = (state_reg == ST_MWRITE) && match_head;
    wr_accept   = RESET && C_WRITE && !C_READ && (match ? !head_locked : !fifo_full);
`ifdef WBUF_FORWARD_EN
    read_ready  = read_done_reg || match;
`else
    read_ready  = read_done_reg;
`endif
    read_miss   = C_READ && !match && !read_done_reg;
    C_BUSYWAIT  = RESET && ((C_READ && !read_ready) || (C_WRITE && !wr_accept));

    read_done_next = read_done_reg;
    if ((state_reg == ST_MREAD) && mem_done) read_done_next = 1'b1;
    else if (!C_READ || !C_BUSYWAIT)         read_done_next = 1'b0;
  end

`ifdef WBUF_FORWARD_EN
  assign C_READDATA = (C_READ && match && !read_done_reg) ? match_data : read_data_reg;
`else
  assign C_READDATA = read_data_reg;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      read_done_reg <= 1'b0;
      read_data_reg <= '0;
      read_addr_reg <= '0;
    end else begin
      read_done_reg <= read_done_next;
      if ((state_reg == ST_MREAD) && mem_done)                read_data_reg <= MEM_READDATA;
      if ((state_reg == ST_IDLE) && (state_next == ST_MREAD)) read_addr_reg <= C_ADDRESS;
    end
  end

  // A full buffer must drain first or writes could stall forever behind a read stream.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fifo_full)        state_next = ST_MWRITE;
        else if (read_miss)   state_next = ST_MREAD;
        else if (!fifo_empty) state_next = ST_MWRITE;
      end
      ST_MWRITE, ST_MREAD: if (!MEM_BUSYWAIT) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_WRITE     = 1'b0;
    MEM_READ      = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_reg)
      ST_MWRITE: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = head.addr;
        MEM_WRITEDATA = head.data;
      end
      ST_MREAD: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = read_addr_reg;
      end
      default: ;
    endcase
  end

endmodule
